// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and result valid/ready channels of alu_cmd_sequencer.
// res_zero/res_neg exist only when ALU_FLAGS_EN is defined.
interface alu_cmd_sequencer_if;
  logic cmd_valid, cmd_ready;
  logic [2:0] cmd_ctrl;
  logic [3:0] cmd_a, cmd_b;
  logic res_valid, res_ready;
  logic [3:0] res_data;
  logic [2:0] res_ctrl;
`ifdef ALU_FLAGS_EN
  logic res_zero, res_neg;
  modport master(output cmd_valid, cmd_ctrl, cmd_a, cmd_b, res_ready,
                 input cmd_ready, res_valid, res_data, res_ctrl, res_zero, res_neg);
  modport slave(input cmd_valid, cmd_ctrl, cmd_a, cmd_b, res_ready,
                output cmd_ready, res_valid, res_data, res_ctrl, res_zero, res_neg);
`else
  modport master(output cmd_valid, cmd_ctrl, cmd_a, cmd_b, res_ready,
                 input cmd_ready, res_valid, res_data, res_ctrl);
  modport slave(input cmd_valid, cmd_ctrl, cmd_a, cmd_b, res_ready,
                output cmd_ready, res_valid, res_data, res_ctrl);
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered issue stage around a combinational 4-bit ALU with a registered result.
// Optional ALU_FLAGS_EN adds registered res_zero/res_neg flags captured with res_data.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  alu_cmd_sequencer_if.slave bus,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_s,
  output logic busy,
  output logic [CW-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t state;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign bus.cmd_ready = !rst && fifo_count != CW'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  // pop only when the result register will be free by the following capture edge
  assign pop = state == IDLE && fifo_count != '0 && (!bus.res_valid || bus.res_ready);
  assign busy = state == DRIVE || fifo_count != '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.cmd_ctrl, bus.cmd_a, bus.cmd_b};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_ctrl <= '0;
`ifdef ALU_FLAGS_EN
      bus.res_zero <= 1'b0;
      bus.res_neg <= 1'b0;
`endif
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;
      if (state == IDLE) begin
        if (pop) begin
          {alu_ctrl, alu_a, alu_b} <= mem[rp];
          state <= DRIVE;
        end
      end else begin
        bus.res_data <= alu_s;
        bus.res_ctrl <= alu_ctrl;
        bus.res_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
        bus.res_zero <= alu_s == 4'd0;
        bus.res_neg <= alu_s[3];
`endif
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized checks of alu_cmd_sequencer against an in-order result scoreboard.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [2:0] alu_ctrl;
  logic busy;
  logic [2:0] fifo_count;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [6:0] exp_q[$];
  logic [6:0] got_q[$];
  int got_cyc[$];

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_s(alu_s),
    .busy(busy), .fifo_count(fifo_count)
  );

  function automatic logic [3:0] alu_f(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
    case (c)
      3'd0: return -a;
      3'd1: return -b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return 4'(a * b);
      default: return a ^ b;
    endcase
  endfunction

  assign alu_s = alu_f(alu_ctrl, alu_a, alu_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready)
      exp_q.push_back({bus.cmd_ctrl, alu_f(bus.cmd_ctrl, bus.cmd_a, bus.cmd_b)});
    if (!rst && bus.res_valid && bus.res_ready) begin
      got_q.push_back({bus.res_ctrl, bus.res_data});
      got_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic push(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    bus.cmd_ctrl = c;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_ctrl = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b required 0", bus.cmd_ready); end
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_ctrl} !== 8'd0) begin
      errors++;
      $display("FAIL rst_res: got valid=%b data=%b ctrl=%b required all 0", bus.res_valid, bus.res_data, bus.res_ctrl);
    end
    checks++;
    if ({busy, fifo_count, alu_a, alu_b, alu_ctrl} !== 15'd0) begin
      errors++;
      $display("FAIL rst_state: got busy=%b count=%0d a=%b b=%b ctrl=%b required all 0", busy, fifo_count, alu_a, alu_b, alu_ctrl);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", bus.cmd_ready); end
    idle(1);
  endtask

  task automatic test_single();
    clear_q();
    bus.res_ready = 1'b1;
    bus.cmd_ctrl = 3'b010;
    bus.cmd_a = 4'd5;
    bus.cmd_b = 4'd6;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", bus.cmd_ready); end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: got count=%0d res_valid=%b required 1 and 0", fifo_count, bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== {3'b010, 4'd5, 4'd6} || busy !== 1'b1 || fifo_count !== 3'd0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e1: got ctrl=%b a=%0d b=%0d busy=%b count=%0d res_valid=%b required 010 5 6 1 0 0",
               alu_ctrl, alu_a, alu_b, busy, fifo_count, bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1011 || bus.res_ctrl !== 3'b010) begin
      errors++;
      $display("FAIL single_e2: got valid=%b data=%b ctrl=%b required 1 1011 010", bus.res_valid, bus.res_data, bus.res_ctrl);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [6:0] want [3];
    want[0] = {3'b011, 4'b1110};
    want[1] = {3'b110, 4'b0101};
    want[2] = {3'b000, 4'b1111};
    clear_q();
    bus.res_ready = 1'b1;
    push(3'b011, 4'd3, 4'd5);
    push(3'b110, 4'd3, 4'd7);
    push(3'b000, 4'd1, 4'($urandom));
    idle(10);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== want[i]) begin
          errors++;
          $display("FAIL b2b_result%0d: got ctrl=%b data=%b required ctrl=%b data=%b", i, got_q[i][6:4], got_q[i][3:0], want[i][6:4], want[i][3:0]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 2", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_full();
    clear_q();
    bus.res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(3'($urandom), 4'(i), 4'($urandom));
      end
      begin
        idle(12);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_state: got count=%0d cmd_ready=%b required 4 and 0", fifo_count, bus.cmd_ready);
        end
        checks++;
        if (exp_q.size() != 5) begin
          errors++;
          $display("FAIL full_accepted: got %0d acceptances required 5", exp_q.size());
        end
        checks++;
        if (bus.res_valid !== 1'b1 || exp_q.size() == 0 || {bus.res_ctrl, bus.res_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL full_held_result: got valid=%b ctrl=%b data=%b required first command's result", bus.res_valid, bus.res_ctrl, bus.res_data);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
      end
    join
    idle(20);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b required 1", bus.cmd_ready); end
    checks++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      errors++;
      $display("FAIL full_count: got %0d results, %0d accepted, required 6 each", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL full_order%0d: got %b required %b", i, got_q[i], exp_q[i]);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_push_pop();
    clear_q();
    bus.res_ready = 1'b1;
    bus.cmd_ctrl = 3'b010;
    bus.cmd_a = 4'd1;
    bus.cmd_b = 4'd1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ctrl = 3'b111;
    bus.cmd_a = 4'b1010;
    bus.cmd_b = 4'b0110;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_before: got count=%0d required 1", fifo_count); end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1 || alu_ctrl !== 3'b010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pp_after: got count=%0d alu_ctrl=%b busy=%b required 1 010 1", fifo_count, alu_ctrl, busy);
    end
    idle(8);
    checks++;
    if (got_q.size() != 2 || got_q[got_q.size()-1] !== {3'b111, 4'b1100}) begin
      errors++;
      $display("FAIL pp_result: got %0d results, last=%b required 2 and 1111100", got_q.size(), got_q.size() ? got_q[got_q.size()-1] : 7'd0);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3'($urandom), 4'($urandom), 4'($urandom));
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL rm_prefill: got count=%0d required 3", fifo_count); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_drive: got count=%0d busy=%b required 2 and 1", fifo_count, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, fifo_count, busy, alu_a, alu_b, alu_ctrl} !== 16'd0) begin
      errors++;
      $display("FAIL rm_cleared: got valid=%b count=%0d busy=%b a=%b b=%b ctrl=%b required all 0",
               bus.res_valid, fifo_count, busy, alu_a, alu_b, alu_ctrl);
    end
    idle(10);
    checks++;
    if (got_q.size() != 0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_result: got %0d results valid=%b required 0 and 0", got_q.size(), bus.res_valid);
    end
  endtask

  task automatic test_random();
    clear_q();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 2));
          push(3'($urandom), 4'($urandom), 4'($urandom));
        end
      end
      begin
        logic hold = 1'b0;
        logic [6:0] held = '0;
        for (int c = 0; c < 600; c++) begin
          @(posedge clk);
          #1 bus.res_ready = 1'($urandom);
          @(negedge clk);
          if (hold) begin
            checks++;
            if (bus.res_valid !== 1'b1 || {bus.res_ctrl, bus.res_data} !== held) begin
              errors++;
              $display("FAIL rand_stable: got valid=%b %b required 1 %b", bus.res_valid, {bus.res_ctrl, bus.res_data}, held);
            end
          end
          hold = bus.res_valid && !bus.res_ready;
          held = {bus.res_ctrl, bus.res_data};
        end
      end
    join
    bus.res_ready = 1'b1;
    idle(20);
    checks++;
    if (got_q.size() != 40 || exp_q.size() != 40) begin
      errors++;
      $display("FAIL rand_count: got %0d results, %0d accepted, required 40 each", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_order%0d: got %b required %b", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    bus.res_ready = 1'b1;
    push(3'b011, 4'd4, 4'd4);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'd0 || bus.res_zero !== 1'b1 || bus.res_neg !== 1'b0) begin
      errors++;
      $display("FAIL flags_zero: got valid=%b data=%b z=%b n=%b required 1 0000 1 0", bus.res_valid, bus.res_data, bus.res_zero, bus.res_neg);
    end
    idle(2);
    push(3'b001, 4'($urandom), 4'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1111 || bus.res_zero !== 1'b0 || bus.res_neg !== 1'b1) begin
      errors++;
      $display("FAIL flags_neg: got valid=%b data=%b z=%b n=%b required 1 1111 0 1", bus.res_valid, bus.res_data, bus.res_zero, bus.res_neg);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
